cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: single-cycle decode in FETCH, ld/st sequenced through MEM_WAIT.
// Optional macro CPU_CTRL_CALL_EN adds callr/call (link pc+2 into R7).
module cpu_control_fsm #(
  parameter int OPCODE_W = 5,
  parameter int MEM_LAT  = 1,
  parameter int WBSRC_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                ALUOp,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                ALUSrc,
  output logic                RegDst,
  output logic [WBSRC_W-1:0]  WBSrc,
  output logic                PCSrc,
  output logic                BrSrc,
  output logic                ExtSel,
  output logic                NZ,
  output logic                BSrc,
  output logic                mem_sel,
  output logic                pc_enable,
  output logic                fetch,
  output logic [1:0]          BrCond,
  output logic                busy,
  output logic                illegal,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_LOAD     = 3'd3,
    S_STORE    = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pend_st, pend_st_nxt;
  logic [4:0] op5;
  logic       upper_nz;

  assign op5 = opcode[4:0];

  generate
    if (OPCODE_W > 5) begin : g_upper
      assign upper_nz = |opcode[OPCODE_W-1:5];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  // Combinational instruction decode, only applied to the outputs while in FETCH.
  logic       d_alu_op, d_reg_write, d_mem_write, d_alu_src, d_reg_dst;
  logic [2:0] d_wb;
  logic       d_pc_src, d_br_src, d_ext_sel, d_nz, d_b_src, d_mem_sel, d_pc_en;
  logic [1:0] d_br_cond;
  logic       d_busy, d_illegal, d_is_ld, d_is_st;

  always_comb begin
    d_alu_op    = 1'b0;
    d_reg_write = 1'b0;
    d_mem_write = 1'b0;
    d_alu_src   = 1'b0;
    d_reg_dst   = 1'b0;
    d_wb        = 3'b001;
    d_pc_src    = 1'b1;
    d_br_src    = 1'b0;
    d_ext_sel   = 1'b0;
    d_nz        = 1'b0;
    d_b_src     = 1'b0;
    d_mem_sel   = 1'b0;
    d_pc_en     = 1'b0;
    d_br_cond   = 2'b00;
    d_busy      = 1'b0;
    d_illegal   = 1'b0;
    d_is_ld     = 1'b0;
    d_is_st     = 1'b0;
    if (upper_nz) begin
      d_illegal = 1'b1;
    end else begin
      case (op5)
        5'b00000: begin d_reg_write = 1'b1; d_wb = 3'b011; end
        5'b00001: begin d_reg_write = 1'b1; d_nz = 1'b1; end
        5'b00010: begin d_reg_write = 1'b1; d_alu_op = 1'b1; d_nz = 1'b1; end
        5'b00011: begin d_alu_op = 1'b1; d_nz = 1'b1; end
        5'b10000: begin d_reg_write = 1'b1; d_wb = 3'b100; d_b_src = 1'b1; end
        5'b10001: begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_nz = 1'b1; end
        5'b10010: begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu_op = 1'b1; d_nz = 1'b1; end
        5'b10011: begin d_alu_src = 1'b1; d_alu_op = 1'b1; d_nz = 1'b1; end
        5'b10110: begin d_reg_write = 1'b1; d_wb = 3'b101; d_b_src = 1'b1; end
        5'b00100: begin d_mem_sel = 1'b1; d_busy = 1'b1; d_is_ld = 1'b1; end
        5'b00101: begin
          d_mem_sel   = 1'b1;
          d_mem_write = 1'b1;
          d_busy      = 1'b1;
          d_is_st     = 1'b1;
        end
        5'b01000, 5'b01001, 5'b01010, 5'b11000, 5'b11001, 5'b11010: begin
          d_pc_src  = 1'b0;
          d_pc_en   = 1'b1;
          d_ext_sel = 1'b1;
          d_br_src  = op5[4];
          d_br_cond = op5[1:0];
        end
`ifdef CPU_CTRL_CALL_EN
        5'b01100, 5'b11100: begin
          d_pc_src    = 1'b0;
          d_pc_en     = 1'b1;
          d_ext_sel   = 1'b1;
          d_br_src    = op5[4];
          d_br_cond   = op5[1:0];
          d_reg_write = 1'b1;
          d_reg_dst   = 1'b1;
          d_wb        = 3'b010;
        end
`endif
        default: d_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      pend_st <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_st <= pend_st_nxt;
    end
  end

  // mem_ready acts as the memory's "done" strobe: it is only looked at once the wait counter has drained.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_st_nxt = pend_st;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (d_is_ld || d_is_st) begin
          state_nxt   = S_MEM_WAIT;
          cnt_nxt     = 3'(MEM_LAT - 1);
          pend_st_nxt = d_is_st;
        end
      end
      S_MEM_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else if (mem_ready) begin
          state_nxt = pend_st ? S_STORE : S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_FETCH;
      S_STORE: state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [2:0] wb3;

  always_comb begin
    ALUOp     = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrc    = 1'b0;
    RegDst    = 1'b0;
    wb3       = 3'b001;
    PCSrc     = 1'b1;
    BrSrc     = 1'b0;
    ExtSel    = 1'b0;
    NZ        = 1'b0;
    BSrc      = 1'b0;
    mem_sel   = 1'b0;
    pc_enable = 1'b0;
    fetch     = 1'b0;
    BrCond    = 2'b00;
    busy      = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUOp     = d_alu_op;
        RegWrite  = d_reg_write;
        MemWrite  = d_mem_write;
        ALUSrc    = d_alu_src;
        RegDst    = d_reg_dst;
        wb3       = d_wb;
        PCSrc     = d_pc_src;
        BrSrc     = d_br_src;
        ExtSel    = d_ext_sel;
        NZ        = d_nz;
        BSrc      = d_b_src;
        mem_sel   = d_mem_sel;
        pc_enable = d_pc_en;
        fetch     = 1'b1;
        BrCond    = d_br_cond;
        busy      = d_busy;
        illegal   = d_illegal;
      end
      S_MEM_WAIT: begin
        mem_sel = 1'b1;
        busy    = 1'b1;
      end
      S_LOAD: begin
        RegWrite = 1'b1;
        wb3      = 3'b000;
        busy     = 1'b1;
        fetch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign WBSrc   = WBSRC_W'(wb3);
  assign state_o = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: two instances (MEM_LAT=3 with 6-bit opcode, MEM_LAT=1) and a scoreboard of full output vectors.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       alu_op, reg_write, mem_write, alu_src, reg_dst;
    logic [2:0] wb;
    logic       pc_src, br_src, ext_sel, nz, b_src, mem_sel, pc_en, fetch;
    logic [1:0] br_cond;
    logic       busy, illegal;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       a_alu_op, a_rw, a_mw, a_alu_src, a_reg_dst, a_pc_src, a_br_src, a_ext_sel;
  logic       a_nz, a_b_src, a_mem_sel, a_pc_en, a_fetch, a_busy, a_illegal;
  logic [2:0] a_wb, a_st;
  logic [1:0] a_br_cond;
  logic       b_alu_op, b_rw, b_mw, b_alu_src, b_reg_dst, b_pc_src, b_br_src, b_ext_sel;
  logic       b_nz, b_b_src, b_mem_sel, b_pc_en, b_fetch, b_busy, b_illegal;
  logic [2:0] b_wb, b_st;
  logic [1:0] b_br_cond;

  ctl_t obs3, obs1;
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_fsm #(.OPCODE_W(6), .MEM_LAT(3), .WBSRC_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(a_alu_op), .RegWrite(a_rw), .MemWrite(a_mw), .ALUSrc(a_alu_src),
    .RegDst(a_reg_dst), .WBSrc(a_wb), .PCSrc(a_pc_src), .BrSrc(a_br_src),
    .ExtSel(a_ext_sel), .NZ(a_nz), .BSrc(a_b_src), .mem_sel(a_mem_sel),
    .pc_enable(a_pc_en), .fetch(a_fetch), .BrCond(a_br_cond), .busy(a_busy),
    .illegal(a_illegal), .state_o(a_st)
  );

  cpu_control_fsm #(.OPCODE_W(5), .MEM_LAT(1), .WBSRC_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .opcode(opcode[4:0]), .mem_ready(mem_ready),
    .ALUOp(b_alu_op), .RegWrite(b_rw), .MemWrite(b_mw), .ALUSrc(b_alu_src),
    .RegDst(b_reg_dst), .WBSrc(b_wb), .PCSrc(b_pc_src), .BrSrc(b_br_src),
    .ExtSel(b_ext_sel), .NZ(b_nz), .BSrc(b_b_src), .mem_sel(b_mem_sel),
    .pc_enable(b_pc_en), .fetch(b_fetch), .BrCond(b_br_cond), .busy(b_busy),
    .illegal(b_illegal), .state_o(b_st)
  );

  assign obs3 = {a_st, a_alu_op, a_rw, a_mw, a_alu_src, a_reg_dst, a_wb, a_pc_src, a_br_src,
                 a_ext_sel, a_nz, a_b_src, a_mem_sel, a_pc_en, a_fetch, a_br_cond, a_busy, a_illegal};
  assign obs1 = {b_st, b_alu_op, b_rw, b_mw, b_alu_src, b_reg_dst, b_wb, b_pc_src, b_br_src,
                 b_ext_sel, b_nz, b_b_src, b_mem_sel, b_pc_en, b_fetch, b_br_cond, b_busy, b_illegal};

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t dflt(input logic [2:0] st);
    ctl_t c;
    c        = '0;
    c.st     = st;
    c.wb     = 3'b001;
    c.pc_src = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_fetch();
    ctl_t c;
    c       = dflt(3'd1);
    c.fetch = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_jump(input logic br_src, input logic [1:0] br_cond);
    ctl_t c;
    c         = f_fetch();
    c.pc_src  = 1'b0;
    c.pc_en   = 1'b1;
    c.ext_sel = 1'b1;
    c.br_src  = br_src;
    c.br_cond = br_cond;
    return c;
  endfunction

  // Scoreboard compare against the selected instance (0: MEM_LAT=3, 1: MEM_LAT=1)
  task automatic cmp_now(input string tag, input bit sel);
    logic [W-1:0] e;
    logic [W-1:0] o;
    o = sel ? obs1 : obs3;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: no expectation queued, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic cyc(input string tag, input bit sel);
    @(negedge clk);
    cmp_now(tag, sel);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input ctl_t e);
    opcode = op;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [5:0] op, input bit sel);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(dflt(3'd0));
    cmp_now("rst_assert", sel);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    opcode = op;
    exp_q.push_back(dflt(3'd0));
    cyc("rst_idle", sel);
  endtask

  ctl_t e;

  initial begin
    reset     = 1'b0;
    opcode    = 6'b000001;
    mem_ready = 1'b1;
    #12;
    exp_q.push_back(dflt(3'd0));
    cmp_now("reset3", 0);
    exp_q.push_back(dflt(3'd0));
    cmp_now("reset1", 1);

    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(dflt(3'd0));
    cyc("rel_idle", 0);

    e = f_fetch(); e.reg_write = 1; e.nz = 1;
    drive(6'b000001, e); cyc("add", 0);
    e = f_fetch(); e.reg_write = 1; e.wb = 3'b011;
    drive(6'b000000, e); cyc("mv", 0);
    e = f_fetch(); e.reg_write = 1; e.alu_op = 1; e.nz = 1;
    drive(6'b000010, e); cyc("sub", 0);
    e = f_fetch(); e.alu_op = 1; e.nz = 1;
    drive(6'b000011, e); cyc("cmp", 0);
    e = f_fetch(); e.reg_write = 1; e.wb = 3'b100; e.b_src = 1;
    drive(6'b010000, e); cyc("mvi", 0);
    e = f_fetch(); e.reg_write = 1; e.alu_src = 1; e.nz = 1;
    drive(6'b010001, e); cyc("addi", 0);
    e = f_fetch(); e.reg_write = 1; e.alu_src = 1; e.alu_op = 1; e.nz = 1;
    drive(6'b010010, e); cyc("subi", 0);
    e = f_fetch(); e.alu_src = 1; e.alu_op = 1; e.nz = 1;
    drive(6'b010011, e); cyc("cmpi", 0);
    e = f_fetch(); e.reg_write = 1; e.wb = 3'b101; e.b_src = 1;
    drive(6'b010110, e); cyc("mvhi", 0);
    drive(6'b011001, f_jump(1'b1, 2'b01)); cyc("jz", 0);
    drive(6'b001010, f_jump(1'b0, 2'b10)); cyc("jnr", 0);
    drive(6'b011000, f_jump(1'b1, 2'b00)); cyc("j", 0);
    drive(6'b001001, f_jump(1'b0, 2'b01)); cyc("jzr", 0);
    e = f_fetch(); e.illegal = 1;
    drive(6'b000111, e); cyc("illegal_op", 0);
    e = f_fetch(); e.illegal = 1;
    drive(6'b100001, e); cyc("illegal_upper", 0);
`ifdef CPU_CTRL_CALL_EN
    e = f_jump(1'b1, 2'b00); e.reg_write = 1; e.reg_dst = 1; e.wb = 3'b010;
    drive(6'b011100, e); cyc("call", 0);
    e = f_jump(1'b0, 2'b00); e.reg_write = 1; e.reg_dst = 1; e.wb = 3'b010;
    drive(6'b001100, e); cyc("callr", 0);
`else
    e = f_fetch(); e.illegal = 1;
    drive(6'b011100, e); cyc("call_illegal", 0);
    e = f_fetch(); e.illegal = 1;
    drive(6'b001100, e); cyc("callr_illegal", 0);
`endif
    e = f_fetch(); e.reg_write = 1; e.nz = 1;
    drive(6'b000001, e); cyc("illegal_clears", 0);

    // ld with MEM_LAT=3, opcode flipped to st while waiting
    e = f_fetch(); e.mem_sel = 1; e.busy = 1;
    drive(6'b000100, e); cyc("ld_issue", 0);
    e = dflt(3'd2); e.mem_sel = 1; e.busy = 1;
    drive(6'b000101, e); cyc("ld_wait1", 0);
    drive(6'b000101, e); cyc("ld_wait2", 0);
    drive(6'b000101, e); cyc("ld_wait3", 0);
    e = dflt(3'd3); e.reg_write = 1; e.wb = 3'b000; e.busy = 1; e.fetch = 1;
    drive(6'b000001, e); cyc("ld_load", 0);
    e = f_fetch(); e.reg_write = 1; e.nz = 1;
    drive(6'b000001, e); cyc("ld_back_fetch", 0);

    // st with MEM_LAT=1 on the second instance, mem_ready low for four cycles
    do_reset(6'b000101, 1);
    mem_ready = 1'b0;
    e = f_fetch(); e.mem_sel = 1; e.mem_write = 1; e.busy = 1;
    drive(6'b000101, e); cyc("st_issue", 1);
    e = dflt(3'd2); e.mem_sel = 1; e.busy = 1;
    drive(6'b000001, e); cyc("st_wait1", 1);
    drive(6'b000001, e); cyc("st_wait2", 1);
    drive(6'b000001, e); cyc("st_wait3", 1);
    mem_ready = 1'b1;
    drive(6'b000001, e); cyc("st_wait4", 1);
    drive(6'b000001, dflt(3'd4)); cyc("st_store", 1);
    e = f_fetch(); e.reg_write = 1; e.nz = 1;
    drive(6'b000001, e); cyc("st_back_fetch", 1);

    // Reset in the second MEM_WAIT cycle of a ld aborts the access
    do_reset(6'b000100, 0);
    e = f_fetch(); e.mem_sel = 1; e.busy = 1;
    drive(6'b000100, e); cyc("abort_issue", 0);
    e = dflt(3'd2); e.mem_sel = 1; e.busy = 1;
    drive(6'b000100, e); cyc("abort_wait1", 0);
    exp_q.push_back(e);
    cmp_now("abort_wait2", 0);
    reset = 1'b0;
    #1;
    exp_q.push_back(dflt(3'd0));
    cmp_now("abort_idle", 0);
    @(negedge clk);
    exp_q.push_back(dflt(3'd0));
    cmp_now("abort_hold", 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    opcode = 6'b000001;
    exp_q.push_back(dflt(3'd0));
    cyc("abort_rel_idle", 0);
    e = f_fetch(); e.reg_write = 1; e.nz = 1;
    drive(6'b000001, e); cyc("abort_resume", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
